// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execute stage and its decoder.
package alu_pkg;

  // 3-bit ALU control word F driven into alu32.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  // Operand stage: decoded control plus latched operands.
  typedef struct packed {
    logic        valid;
    alu_ctrl_t   f;
    logic        sgn;
    logic        illegal;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } s1_t;

  // Result stage: everything the writeback stage sees.
  typedef struct packed {
    logic        valid;
    logic [31:0] y;
    logic        zero;
    logic        trap;
    logic        illegal;
    logic [4:0]  rd;
  } s2_t;

endpackage

// File: rtl/alu32.sv
// 32-bit ALU: F[2] inverts B (and supplies the carry-in), F[1:0] selects
// and / or / sum / set-less-than. Overflow is the signed add/sub overflow.
module alu32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  F,
  output logic [31:0] Y,
  output logic        Zero,
  output logic        Overflow
);

  logic [31:0] bb;
  logic [31:0] sum;

  // Datapath: conditional invert, adder and result select.
  always_comb begin
    bb  = F[2] ? ~B : B;
    sum = A + bb + {31'd0, F[2]};
    case (F[1:0])
      2'b00:   Y = A & bb;
      2'b01:   Y = A | bb;
      2'b10:   Y = sum;
      default: Y = {31'd0, sum[31]};
    endcase
    Zero     = (Y == 32'd0);
    Overflow = (F[1:0] == 2'b10) & (A[31] == bb[31]) & (sum[31] != A[31]);
  end

endmodule

// File: rtl/alu_dec.sv
// aluop/funct decoder: ALU control word, signed-op flag and illegal flag.
module alu_dec
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output alu_ctrl_t  f,
  output logic       sgn,
  output logic       illegal
);

  // Map the op class (and funct for R-type) onto the ALU control word.
  always_comb begin
    f       = ALU_ADD;
    sgn     = 1'b0;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: f = ALU_ADD;
      ALUOP_SUB: f = ALU_SUB;
      ALUOP_OR:  f = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD:  begin f = ALU_ADD; sgn = 1'b1; end
          FUNCT_ADDU: f = ALU_ADD;
          FUNCT_SUB:  begin f = ALU_SUB; sgn = 1'b1; end
          FUNCT_SUBU: f = ALU_SUB;
          FUNCT_AND:  f = ALU_AND;
          FUNCT_OR:   f = ALU_OR;
          FUNCT_SLT:  f = ALU_SLT;
          default:    begin f = ALU_ADD; illegal = 1'b1; end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-register execute stage around alu32: S1 holds decoded op + operands,
// S2 holds the registered result presented to writeback.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter bit TRAP_ON_OVF = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  aluop,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic [4:0]  out_rd,
  output logic        out_trap,
  output logic        out_illegal,
  output logic        ovf_sticky,
  input  logic        ovf_clr
);

  s1_t         s1;
  s2_t         s2;
  alu_ctrl_t   dec_f;
  logic        dec_sgn;
  logic        dec_ill;
  logic [31:0] alu_y;
  logic        alu_zero;
  logic        alu_ovf;
  logic        trap_nx;
  logic        s2_adv;

  alu_dec u_dec (
    .aluop   (aluop),
    .funct   (funct),
    .f       (dec_f),
    .sgn     (dec_sgn),
    .illegal (dec_ill)
  );

  alu32 u_alu (
    .A        (s1.a),
    .B        (s1.b),
    .F        (s1.f),
    .Y        (alu_y),
    .Zero     (alu_zero),
    .Overflow (alu_ovf)
  );

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; valid never depends on ready, and a producer holding valid
  // keeps its payload stable until the transfer. S2 may take a new entry when
  // it is empty or draining; S1 may take input when empty or moving into S2.
  always_comb begin
    s2_adv   = !s2.valid | out_ready;
    in_ready = rst_n & (!s1.valid | s2_adv) & !flush;
    trap_nx  = TRAP_ON_OVF & s1.sgn & alu_ovf;
  end

  // Operand stage register.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      s1 <= '0;
    end else if (in_valid && in_ready) begin
      s1 <= '{valid: 1'b1, f: dec_f, sgn: dec_sgn, illegal: dec_ill,
              a: src_a, b: src_b, rd: rd};
    end else if (s2_adv) begin
      s1.valid <= 1'b0;
    end
  end

  // Result stage register; captures S1 (including bubbles) whenever it can advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2 <= '0;
    end else if (flush) begin
      s2.valid <= 1'b0;
    end else if (s2_adv) begin
      s2 <= '{valid: s1.valid, y: alu_y, zero: alu_zero, trap: trap_nx,
              illegal: s1.illegal, rd: s1.rd};
    end
  end

  // Sticky overflow: a trapping result entering S2 beats a coincident clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (!flush && s2_adv && s1.valid && trap_nx) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

  assign out_valid   = s2.valid;
  assign out_result  = s2.y;
  assign out_zero    = s2.zero;
  assign out_rd      = s2.rd;
  assign out_trap    = s2.trap;
  assign out_illegal = s2.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: expected results are queued when an op
// is accepted and a monitor pops/compares them as the stage hands them off.
module tb_alu_exec_stage;

  localparam int W = 40; // {result, zero, trap, illegal, rd}

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_trap;
  logic        out_illegal;
  logic        ovf_sticky;
  logic        ovf_clr;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  alu_exec_stage #(.TRAP_ON_OVF(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .aluop       (aluop),
    .funct       (funct),
    .src_a       (src_a),
    .src_b       (src_b),
    .rd          (rd),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_rd      (out_rd),
    .out_trap    (out_trap),
    .out_illegal (out_illegal),
    .ovf_sticky  (ovf_sticky),
    .ovf_clr     (ovf_clr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic [31:0] y, input logic z,
                                      input logic t, input logic il,
                                      input logic [4:0] r);
    return {y, z, t, il, r};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [1:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] r, input logic push,
                      input logic [W-1:0] exp);
    bit done;
    done     = 1'b0;
    aluop    = op;
    funct    = fn;
    src_a    = a;
    src_b    = b;
    rd       = r;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", W'(0), W'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", mk(out_result, out_zero, out_trap, out_illegal, out_rd), W'(0));
      end else begin
        chk("result", mk(out_result, out_zero, out_trap, out_illegal, out_rd), exp_q.pop_front());
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; aluop = 2'b00; funct = 6'd0;
    src_a = 32'd0; src_b = 32'd0; rd = 5'd0; flush = 1'b0;
    out_ready = 1'b1; ovf_clr = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_outputs", mk(out_result, out_zero, out_trap, out_illegal, out_rd), W'(0));
    chk("rst_valid_sticky", W'({out_valid, ovf_sticky}), W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", W'(in_ready), W'(1));

    // add 5+7 with latency check.
    send(2'b10, 6'b100000, 32'd5, 32'd7, 5'd1, 1'b1, mk(32'd12, 1'b0, 1'b0, 1'b0, 5'd1));
    chk("lat_not_yet", W'(out_valid), W'(0));
    @(posedge clk); #1;
    chk("lat_valid", W'(out_valid), W'(1));
    idle(2);

    // Signed sub overflow traps; subu does not.
    send(2'b10, 6'b100010, 32'h8000_0000, 32'd1, 5'd2, 1'b1, mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd2));
    send(2'b10, 6'b100011, 32'h8000_0000, 32'd1, 5'd3, 1'b1, mk(32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd3));
    idle(3);
    chk("sticky_set", W'(ovf_sticky), W'(1));
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    chk("sticky_clr", W'(ovf_sticky), W'(0));

    // Back-pressure: fill both stages, stall 3 cycles, release.
    out_ready = 1'b0;
    send(2'b10, 6'b101010, 32'd3, 32'd5, 5'd4, 1'b1, mk(32'd1, 1'b0, 1'b0, 1'b0, 5'd4));
    send(2'b10, 6'b100100, 32'hF0, 32'h3C, 5'd5, 1'b1, mk(32'h30, 1'b0, 1'b0, 1'b0, 5'd5));
    aluop = 2'b11; funct = 6'd0; src_a = 32'hF0; src_b = 32'h0F; rd = 5'd6;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready_low", W'(in_ready), W'(0));
      chk("bp_hold", mk(out_result, 1'b0, 1'b0, 1'b0, 5'd0), mk(32'd1, 1'b0, 1'b0, 1'b0, 5'd0));
      chk("bp_valid", W'(out_valid), W'(1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b11, 6'd0, 32'hF0, 32'h0F, 5'd6, 1'b1, mk(32'hFF, 1'b0, 1'b0, 1'b0, 5'd6));
    send(2'b01, 6'd0, 32'd9, 32'd9, 5'd7, 1'b1, mk(32'd0, 1'b1, 1'b0, 1'b0, 5'd7));
    idle(3);
    chk("bp_drained", W'(exp_q.size()), W'(0));

    // Flush with both stages full; the trapping op in S2 already set sticky.
    out_ready = 1'b0;
    send(2'b10, 6'b100010, 32'h8000_0000, 32'd1, 5'd10, 1'b0, W'(0));
    send(2'b00, 6'd0, 32'd1, 32'd2, 5'd11, 1'b0, W'(0));
    chk("pre_flush_sticky", W'(ovf_sticky), W'(1));
    aluop = 2'b00; src_a = 32'd3; src_b = 32'd4; rd = 5'd12;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", W'(in_ready), W'(0));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", W'(out_valid), W'(0));
    chk("flush_sticky", W'(ovf_sticky), W'(1));
    out_ready = 1'b1;
    idle(3);
    chk("flush_empty", W'(out_valid), W'(0));
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;

    // Illegal funct: add result, never traps even on signed overflow.
    send(2'b10, 6'b111111, 32'h7FFF_FFFF, 32'd1, 5'd13, 1'b1, mk(32'h8000_0000, 1'b0, 1'b0, 1'b1, 5'd13));
    idle(3);
    chk("illegal_no_sticky", W'(ovf_sticky), W'(0));

    // Set and clear on the same edge: set wins.
    send(2'b10, 6'b100010, 32'h8000_0000, 32'd1, 5'd14, 1'b1, mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd14));
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("set_beats_clr", W'(ovf_sticky), W'(1));
    idle(3);

    // Reset mid-stream with a stalled trap result in S2.
    out_ready = 1'b0;
    send(2'b10, 6'b100010, 32'h8000_0000, 32'd1, 5'd20, 1'b0, W'(0));
    send(2'b00, 6'd0, 32'd1, 32'd1, 5'd21, 1'b0, W'(0));
    @(negedge clk);
    chk("stall_trap", W'({out_valid, out_trap}), W'(2'b11));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_outputs", mk(out_result, out_zero, out_trap, out_illegal, out_rd), W'(0));
    chk("midrst_flags", W'({out_valid, ovf_sticky, in_ready}), W'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(4);
    chk("no_stale_result", W'(out_valid), W'(0));
    chk("queue_empty", W'(exp_q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
